period_meter: RTL

- Measures one full period and the high time of a slow, asynchronous square-wave input, in clk_50mhz cycles.
- Used to check divided clocks such as the 50 MHz -> ~12 Hz toggle output produced elsewhere in the design. It is the checking end of that interface.
- Software or a top-level FSM pulses start. The block later returns period/high_time with a one-cycle valid pulse, or flags timeout.

---
 rtl/period_meter_pkg.sv | 17 +
 rtl/period_meter_sync_edge.sv | 35 +++
 rtl/period_meter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
package period_meter_pkg;

  localparam int DEF_CNT_W = 26;
  localparam int CLK_HZ    = 50_000_000;

  // One second of clk_50mhz cycles: the longest a measurement may take.
  localparam logic [DEF_CNT_W-1:0] DEF_TIMEOUT = DEF_CNT_W'(CLK_HZ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/period_meter_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input plus rise/fall detection.
// Both edges see the same latency, so differences between edge times are exact.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  // Shift the raw input through the synchroniser chain and keep one delayed copy.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge pulses are one clock wide and mutually exclusive.
  always_comb begin
    level = sync_q[SYNC_STAGES-1];
    rise  = level & ~s_d;
    fall  = ~level & s_d;
  end

endmodule

// File: rtl/period_meter.sv
// Measures one period and the high time of a slow asynchronous square wave.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | no measurement running; waits for start
//   WAIT_RISE | armed; waits for the first synchronised rising edge
//   MEAS_HIGH | counting the high phase; fall latches the high time
//   MEAS_LOW  | counting the low phase; next rise completes the measurement
//
// tcnt runs in every non-IDLE state and bounds the whole measurement. A
// completing rise in the final allowed cycle still counts as a result.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             busy,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TC_LAST = TIMEOUT - 1'b1;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] pcnt_q, pcnt_nxt;
  logic [CNT_W-1:0] tcnt_q, tcnt_nxt;
  logic [CNT_W-1:0] hi_tmp_q, hi_tmp_nxt;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic [CNT_W-1:0] high_q, high_nxt;
  logic             valid_q, valid_nxt;
  logic             timeout_q, timeout_nxt;
  logic             to_evt_q, to_evt_nxt;
  logic             tc_hit;

  logic sig_rise;
  logic sig_fall;
  logic sig_level_unused;

  // Level is not needed: all timing comes from the edge pulses.
  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_50mhz(clk_50mhz),
    .rst      (rst),
    .sig_in   (sig_in),
    .level    (sig_level_unused),
    .rise     (sig_rise),
    .fall     (sig_fall)
  );

  // State, counters and result registers.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      tcnt_q    <= '0;
      hi_tmp_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      to_evt_q  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      pcnt_q    <= pcnt_nxt;
      tcnt_q    <= tcnt_nxt;
      hi_tmp_q  <= hi_tmp_nxt;
      period_q  <= period_nxt;
      high_q    <= high_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
      to_evt_q  <= to_evt_nxt;
    end
  end

  // Next-state and datapath decisions; holds everything unless a state acts.
  always_comb begin
    state_nxt   = state_q;
    pcnt_nxt    = pcnt_q;
    tcnt_nxt    = tcnt_q;
    hi_tmp_nxt  = hi_tmp_q;
    period_nxt  = period_q;
    high_nxt    = high_q;
    valid_nxt   = 1'b0;
    timeout_nxt = timeout_q;
    to_evt_nxt  = 1'b0;
    tc_hit      = (tcnt_q == TC_LAST);

    case (state_q)
      IDLE: begin
        // The cycle showing valid or a fresh timeout does not accept start.
        if (start && !valid_q && !to_evt_q) begin
          state_nxt   = WAIT_RISE;
          tcnt_nxt    = '0;
          timeout_nxt = 1'b0;
        end
      end

      WAIT_RISE: begin
        tcnt_nxt = tcnt_q + 1'b1;
        if (tc_hit) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
          to_evt_nxt  = 1'b1;
        end else if (sig_rise) begin
          state_nxt = MEAS_HIGH;
          pcnt_nxt  = CNT_W'(1);
        end
      end

      MEAS_HIGH: begin
        tcnt_nxt = tcnt_q + 1'b1;
        pcnt_nxt = pcnt_q + 1'b1;
        if (tc_hit) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
          to_evt_nxt  = 1'b1;
        end else if (sig_fall) begin
          hi_tmp_nxt = pcnt_q;
          state_nxt  = MEAS_LOW;
        end
      end

      MEAS_LOW: begin
        tcnt_nxt = tcnt_q + 1'b1;
        pcnt_nxt = pcnt_q + 1'b1;
        // A completing rise outranks the final timeout cycle.
        if (sig_rise) begin
          period_nxt = pcnt_q;
          high_nxt   = hi_tmp_q;
          valid_nxt  = 1'b1;
          state_nxt  = IDLE;
        end else if (tc_hit) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
          to_evt_nxt  = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Busy follows the state register so it drops in the valid/timeout cycle.
  always_comb begin
    busy      = (state_q != IDLE);
    period    = period_q;
    high_time = high_q;
    valid     = valid_q;
    timeout   = timeout_q;
  end

endmodule
